zxuno_regport: RTL
==================

# zxuno_regport

Sequencer for the ZX-UNO internal register bus. It decodes Z80 I/O cycles on the address port (default 16'hFC3B) and the data port (default 16'hFD3B), and holds the selected register number. For data-port cycles it generates clean read and write strobes toward the register peripherals, and it arbitrates their shared read-back data onto the CPU data bus. It sits between the CPU bus glue and all register peripherals; ID-string, configuration and scancode registers all hang off it.

## Interface
- NPERIPH, 4, number of register peripherals on the read-back bus (1..8)
- ADDR_PORT, 16'hFC3B, I/O address of the register-number port
- DATA_PORT, 16'hFD3B, I/O address of the register-data port
- clk  in  1  system clock; all CPU signals are already synchronous to it
- rst_n  in  1  reset, synchronous, active-low
- cpu_a  in  16  Z80 address bus
- cpu_din  in  8  Z80 write data
- iorq_n, rd_n, wr_n  in  1 each  Z80 strobes, active-low
- cpu_dout  out  8  read data toward CPU
- cpu_oe_n  out  1  low while this block drives cpu_dout
- zxuno_addr  out  8  currently selected register number
- zxuno_regrd  out  1  level; high for the duration of a data-port read
- zxuno_regwr  out  1  one-cycle write strobe
- zxuno_dout  out  8  write data, valid while zxuno_regwr is high and held afterwards
- periph_oe_n  in  NPERIPH  per-peripheral output enable, active-low
- periph_dout  in  8*NPERIPH  per-peripheral data; slice i = bits 8i+7:8i
- collision  out  1  sticky; set if more than one peripheral drove the bus in a cycle

## Operation
- Address decode uses a full 16-bit compare.
  - rdcyc = !iorq_n & !rd_n
  - wrcyc = !iorq_n & !wr_n
  - cycle_end = iorq_n | (rd_n & wr_n)
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_DONE, WAIT_END.
- IDLE transitions:
  - rdcyc & a==ADDR_PORT -> RD_ADDR
  - rdcyc & a==DATA_PORT -> RD_DATA
  - wrcyc & a==ADDR_PORT -> latch zxuno_addr<=cpu_din, clear collision -> WR_DONE
  - wrcyc & a==DATA_PORT -> zxuno_dout<=cpu_din, zxuno_regwr<=1 for exactly one cycle -> WR_DONE
  - any other address: stay in IDLE
- RD_ADDR: cpu_oe_n=0, cpu_dout=zxuno_addr. On cycle_end -> IDLE.
- RD_DATA:
  - zxuno_regrd=1 and cpu_oe_n=0.
  - cpu_dout = slice of the lowest index i with periph_oe_n[i]=0; 8'hFF if none.
  - If two or more periph_oe_n are low in any cycle, set collision.
  - On cycle_end -> IDLE.
- WR_DONE: wait for cycle_end -> IDLE. One Z80 write produces exactly one zxuno_regwr or address latch, however long the strobe is held.
- WAIT_END: entered on reset. Goes to IDLE once cycle_end is seen. A bus cycle already in progress when reset is released is ignored entirely.
- Outside RD_ADDR/RD_DATA: cpu_oe_n=1, cpu_dout=8'hFF.
- Simultaneous rd_n and wr_n low (illegal): treated as a read. No write strobe is issued.
- collision is cleared only by reset or by a write to ADDR_PORT.

## Timing
- Reset values:
  - state=WAIT_END
  - zxuno_addr=8'h00, zxuno_dout=8'h00
  - zxuno_regrd=0, zxuno_regwr=0, collision=0
  - cpu_oe_n=1, cpu_dout=8'hFF
- zxuno_regrd, zxuno_regwr, zxuno_addr, zxuno_dout and collision are registered.
- cpu_oe_n and cpu_dout are combinational from state and periph inputs.
- Read sequence:
  - Qualifying strobe first seen at edge N.
  - State changes at edge N+1; zxuno_regrd and cpu_oe_n are low/high accordingly from that point.
  - Peripheral data reaches cpu_dout in the same cycle the peripheral asserts oe_n.
- Read end: cycle_end seen at edge M; zxuno_regrd falls and cpu_oe_n rises after edge M+1. Peripherals detecting the regrd falling edge (auto-incrementing readers) therefore see exactly one falling edge per CPU read.
- Write sequence: strobe seen at edge N -> zxuno_regwr high for the single cycle after edge N+1 (or zxuno_addr updated at N+1).
- Back-to-back cycles: a new cycle is accepted only from IDLE, so at least one clk with cycle_end is required between cycles. The Z80 guarantees this.
- Reset mid-operation (in RD_DATA or after a regwr): outputs return to reset values at the next edge. The pending strobe is never re-issued.

## Test plan
- Address-port round trip: write 8'hFF to 16'hFC3B, then read 16'hFC3B -> cpu_dout=8'hFF, cpu_oe_n low only during the read, zxuno_regwr never asserts.
- Data read: read 16'hFD3B with periph_oe_n=4'b1101 and slice1=8'h54 -> cpu_dout=8'h54, zxuno_regrd high from N+1 through one cycle after rd_n rises, exactly one regrd falling edge.
- Long write strobe: write 8'hA5 to 16'hFD3B with wr_n held low 10 clk -> zxuno_regwr high exactly 1 cycle, zxuno_dout=8'hA5 afterwards.
- Arbitration: periph_oe_n=4'b0110 during a data read -> cpu_dout=slice0, collision=1, which persists until a write to 16'hFC3B clears it to 0.
- No responder and foreign port: read 16'hFD3B with all periph_oe_n high -> cpu_dout=8'hFF, cpu_oe_n=0. Read 16'hFE3B -> cpu_oe_n=1 and no strobes.
- Reset mid-read: assert rst_n=0 for 1 clk inside RD_DATA with rd_n still low -> regrd=0 and cpu_oe_n=1 at next edge, no new regrd until iorq_n rises and a fresh cycle starts.

Source files
------------

// File: rtl/zxuno_regport.sv
// zxuno_regport: ZX-UNO internal register bus sequencer.
// Decodes Z80 I/O cycles on the address and data ports, strobes peripherals and arbitrates read-back.
`default_nettype none

module zxuno_regport #(
  parameter int          NPERIPH   = 4,
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          cpu_a,
  input  logic [7:0]           cpu_din,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  output logic [7:0]           cpu_dout,
  output logic                 cpu_oe_n,
  output logic [7:0]           zxuno_addr,
  output logic                 zxuno_regrd,
  output logic                 zxuno_regwr,
  output logic [7:0]           zxuno_dout,
  input  logic [NPERIPH-1:0]   periph_oe_n,
  input  logic [8*NPERIPH-1:0] periph_dout,
  output logic                 collision
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ADDR  = 3'd1,
    ST_RD_DATA  = 3'd2,
    ST_WR_DONE  = 3'd3,
    ST_WAIT_END = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        regwr_q, regwr_d;
  logic        regrd_q, regrd_d;
  logic        coll_q, coll_d;

  // Bus sample stage; deliberately not reset so a cycle in flight at reset release stays visible.
  logic [15:0] a_q;
  logic [7:0]  din_q;
  logic        iorq_n_q, rd_n_q, wr_n_q;

  logic        rdcyc, wrcyc, cycle_end, hit_addr, hit_data;
  logic [7:0]  pick;
  logic        found, multi;

  always_ff @(posedge clk) begin
    a_q      <= cpu_a;
    din_q    <= cpu_din;
    iorq_n_q <= iorq_n;
    rd_n_q   <= rd_n;
    wr_n_q   <= wr_n;
  end

  // Read wins when both strobes are low, so an illegal cycle never writes.
  always_comb begin
    rdcyc     = !iorq_n_q && !rd_n_q;
    wrcyc     = !iorq_n_q && !wr_n_q && rd_n_q;
    cycle_end = iorq_n_q || (rd_n_q && wr_n_q);
    hit_addr  = (a_q == ADDR_PORT);
    hit_data  = (a_q == DATA_PORT);
  end

  // Lowest-index enabled peripheral owns the bus; any second enable is a collision.
  always_comb begin
    pick  = 8'hFF;
    found = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NPERIPH; i++) begin
      if (!periph_oe_n[i]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found = 1'b1;
          pick  = periph_dout[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    regwr_d = 1'b0;
    coll_d  = coll_q;
    case (state_q)
      ST_IDLE: begin
        if (rdcyc && hit_addr) begin
          state_d = ST_RD_ADDR;
        end else if (rdcyc && hit_data) begin
          state_d = ST_RD_DATA;
        end else if (wrcyc && hit_addr) begin
          addr_d  = din_q;
          coll_d  = 1'b0;
          state_d = ST_WR_DONE;
        end else if (wrcyc && hit_data) begin
          wdata_d = din_q;
          regwr_d = 1'b1;
          state_d = ST_WR_DONE;
        end
      end
      ST_RD_ADDR: begin
        if (cycle_end) state_d = ST_IDLE;
      end
      ST_RD_DATA: begin
        if (multi) coll_d = 1'b1;
        if (cycle_end) state_d = ST_IDLE;
      end
      ST_WR_DONE, ST_WAIT_END: begin
        if (cycle_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    regrd_d = (state_d == ST_RD_DATA);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_END;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      regwr_q <= 1'b0;
      regrd_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      regwr_q <= regwr_d;
      regrd_q <= regrd_d;
      coll_q  <= coll_d;
    end
  end

  always_comb begin
    cpu_oe_n = 1'b1;
    cpu_dout = 8'hFF;
    if (state_q == ST_RD_ADDR) begin
      cpu_oe_n = 1'b0;
      cpu_dout = addr_q;
    end else if (state_q == ST_RD_DATA) begin
      cpu_oe_n = 1'b0;
      cpu_dout = pick;
    end
  end

  assign zxuno_addr  = addr_q;
  assign zxuno_dout  = wdata_q;
  assign zxuno_regwr = regwr_q;
  assign zxuno_regrd = regrd_q;
  assign collision   = coll_q;

endmodule

`default_nettype wire
